dest_pop_arbiter: RTL and testbench

- Downstream consumer of full_logic's two destination FIFOs (D0, D1).
- Drives D0_pop/D1_pop, captures the popped words and merges them into one valid/ready output stream tagged with source destination.
- Round-robin fair between D0 and D1; only runs while full_logic reports active_out.
- Counts delivered words per destination for the probador to compare against words written.

---
 rtl/dest_pop_pkg.sv | 17 +
 rtl/dest_out_queue.sv | 65 ++++++
 rtl/dest_pop_arbiter.sv | 133 +++++++++++++
 tb/tb_dest_pop_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dest_pop_pkg.sv
// Shared definitions for the destination pop arbiter: FSM state encoding,
// destination tags and default widths.
package dest_pop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/dest_out_queue.sv
// Two-entry {dest, data} FIFO feeding the merged output stream.
// The head entry is always visible; head_valid says whether it holds a word.
module dest_out_queue
  import dest_pop_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq,
  input  logic              enq_dest,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic              head_valid,
  output logic              head_dest,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W:0] mem_reg [2];
  logic            rd_ptr_reg;
  logic            wr_ptr_reg;
  logic [1:0]      count_reg;
  logic            do_enq;
  logic            do_deq;

  // Guard both ends so a stray request can never corrupt the occupancy.
  assign do_deq = deq && (count_reg != 2'd0);
  assign do_enq = enq && ((count_reg != 2'd2) || do_deq);

  // Storage entries are cleared on reset so data_out/dest_out start at zero.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (do_enq && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= {enq_dest, enq_data};
        end
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; simultaneous enq/deq keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_deq) rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_enq, do_deq})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_valid             = (count_reg != 2'd0);
  assign {head_dest, head_data} = mem_reg[rd_ptr_reg];
  assign occupancy              = count_reg;

endmodule

// File: rtl/dest_pop_arbiter.sv
// Pops the two destination FIFOs of full_logic, merges the words into one
// valid/ready stream tagged with the source and counts delivered words.
// Build option: define DEST_POP_STRICT_PRIO_EN to replace round-robin with
// strict priority (D0 over D1).
module dest_pop_arbiter
  import dest_pop_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              empty_fifo_D0,
  input  logic              empty_fifo_D1,
  input  logic [DATA_W-1:0] data_out_D0,
  input  logic [DATA_W-1:0] data_out_D1,
  output logic              D0_pop,
  output logic              D1_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              dest_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1,
  output logic              busy
);

  state_t           state_reg;
  logic             inflight_reg;
  logic             inflight_dest_reg;
  logic [CNT_W-1:0] cnt_d0_reg;
  logic [CNT_W-1:0] cnt_d1_reg;
  logic [1:0]       occupancy;
  logic             deq;
  logic [2:0]       load;
  logic             pop_ok;
  logic             sel_d1;
  logic             pop_any;

`ifndef DEST_POP_STRICT_PRIO_EN
  logic             rr_ptr_reg;   // destination that wins the next tie
`endif

  assign deq = valid_out && ready_in;

  // Pop decision: room must exist for the word counting what is already
  // queued, what is in flight and what leaves this cycle.
  always_comb begin
    load    = {1'b0, occupancy} + {2'b00, inflight_reg} - {2'b00, deq};
    pop_ok  = !reset && (state_reg == RUN) && (load < 3'd2);
`ifdef DEST_POP_STRICT_PRIO_EN
    sel_d1  = empty_fifo_D0;
`else
    sel_d1  = empty_fifo_D0 ? DEST_D1 : (empty_fifo_D1 ? DEST_D0 : rr_ptr_reg);
`endif
    pop_any = pop_ok && !(empty_fifo_D0 && empty_fifo_D1);
    D0_pop  = pop_any && (sel_d1 == DEST_D0);
    D1_pop  = pop_any && (sel_d1 == DEST_D1);
  end

`ifndef DEST_POP_STRICT_PRIO_EN
  // Round-robin pointer: after serving one side, prefer the other.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= DEST_D0;
    end else if (D0_pop) begin
      rr_ptr_reg <= DEST_D1;
    end else if (D1_pop) begin
      rr_ptr_reg <= DEST_D0;
    end
  end
`endif

  // Track the word whose FIFO data appears on the cycle after its pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg      <= 1'b0;
      inflight_dest_reg <= DEST_D0;
    end else begin
      inflight_reg      <= pop_any;
      inflight_dest_reg <= D1_pop;
    end
  end

  dest_out_queue #(.DATA_W(DATA_W)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .enq        (inflight_reg),
    .enq_dest   (inflight_dest_reg),
    .enq_data   (inflight_dest_reg ? data_out_D1 : data_out_D0),
    .deq        (deq),
    .head_valid (valid_out),
    .head_dest  (dest_out),
    .head_data  (data_out),
    .occupancy  (occupancy)
  );

  // Run/drain control: leave DRAIN only once nothing is queued or in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (active_in) state_reg <= RUN;
        RUN:     if (!active_in) state_reg <= DRAIN;
        DRAIN: begin
          if (active_in)
            state_reg <= RUN;
          else if (!inflight_reg && (occupancy == 2'd0))
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Saturating delivered-word counters, one per source destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_d0_reg <= '0;
      cnt_d1_reg <= '0;
    end else if (deq) begin
      if ((dest_out == DEST_D0) && (cnt_d0_reg != '1)) cnt_d0_reg <= cnt_d0_reg + 1'b1;
      if ((dest_out == DEST_D1) && (cnt_d1_reg != '1)) cnt_d1_reg <= cnt_d1_reg + 1'b1;
    end
  end

  assign cnt_D0 = cnt_d0_reg;
  assign cnt_D1 = cnt_d1_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_dest_pop_arbiter.sv
// Directed bench for dest_pop_arbiter with simple 1-cycle-latency FIFO
// models on both destinations, plus a second instance with CNT_W = 2.
module tb_dest_pop_arbiter;

  localparam int DW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic active_in;
  logic ready_in;

  // FIFO models: tail written by the stimulus, head advanced on pops.
  logic [DW-1:0] mem0 [64];
  logic [DW-1:0] mem1 [64];
  logic [5:0]    head0 = 6'd0, tail0 = 6'd0, head1 = 6'd0, tail1 = 6'd0;
  logic [DW-1:0] dout0 = '0, dout1 = '0;
  logic          empty0, empty1;
  assign empty0 = (head0 == tail0);
  assign empty1 = (head1 == tail1);

  logic          D0_pop, D1_pop, dest_out, valid_out, busy;
  logic [DW-1:0] data_out;
  logic [7:0]    cnt_D0, cnt_D1;

  dest_pop_arbiter #(.DATA_W(DW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .empty_fifo_D0(empty0), .empty_fifo_D1(empty1),
    .data_out_D0(dout0), .data_out_D1(dout1),
    .D0_pop(D0_pop), .D1_pop(D1_pop),
    .data_out(data_out), .dest_out(dest_out), .valid_out(valid_out),
    .ready_in(ready_in), .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .busy(busy)
  );

  always @(posedge clk) begin
    if (D0_pop) begin dout0 <= mem0[head0]; head0 <= head0 + 6'd1; end
    if (D1_pop) begin dout1 <= mem1[head1]; head1 <= head1 + 6'd1; end
  end

  // Second instance: narrow counters, D0-only traffic.
  logic          active2;
  logic [5:0]    head2 = 6'd0, tail2 = 6'd0;
  logic [DW-1:0] dout2 = '0;
  logic          empty2;
  logic          D0_pop2, D1_pop2, dest2, valid2, busy2;
  logic [DW-1:0] data2;
  logic [1:0]    cnt2_D0, cnt2_D1;
  assign empty2 = (head2 == tail2);

  dest_pop_arbiter #(.DATA_W(DW), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .active_in(active2),
    .empty_fifo_D0(empty2), .empty_fifo_D1(1'b1),
    .data_out_D0(dout2), .data_out_D1(6'h00),
    .D0_pop(D0_pop2), .D1_pop(D1_pop2),
    .data_out(data2), .dest_out(dest2), .valid_out(valid2),
    .ready_in(1'b1), .cnt_D0(cnt2_D0), .cnt_D1(cnt2_D1), .busy(busy2)
  );

  always @(posedge clk) begin
    if (D0_pop2) begin dout2 <= head2 + 6'h3; head2 <= head2 + 6'd1; end
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push0(input logic [DW-1:0] v);
    mem0[tail0] = v;
    tail0 = tail0 + 6'd1;
  endtask

  task automatic push1(input logic [DW-1:0] v);
    mem1[tail1] = v;
    tail1 = tail1 + 6'd1;
  endtask

  // Per-cycle expectations for the 3+3 word phase (bit i = cycle i).
  logic [8:0]    e_p0, e_p1, e_v;
  logic [DW-1:0] e_d [9];
  logic          e_dst [9];

  initial begin
`ifdef DEST_POP_STRICT_PRIO_EN
    e_p0  = 9'b000000111;
    e_p1  = 9'b000111000;
    e_d   = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h11, 6'h12, 6'h13, 6'h00};
    e_dst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    e_p0  = 9'b000010101;
    e_p1  = 9'b000101010;
    e_d   = '{6'h00, 6'h00, 6'h01, 6'h11, 6'h02, 6'h12, 6'h03, 6'h13, 6'h00};
    e_dst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    e_v = 9'b011111100;

    // Reset with both FIFOs loaded and active high: nothing may move.
    reset = 1'b1; active_in = 1'b1; ready_in = 1'b1; active2 = 1'b0;
    push0(6'h01); push0(6'h02); push0(6'h03);
    push1(6'h11); push1(6'h12); push1(6'h13);
    tail2 = 6'd5;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_pops", {30'd0, D1_pop, D0_pop}, 32'd0);
      chk("rst_valid_busy", {30'd0, valid_out, busy}, 32'd0);
      chk("rst_data_dest", {25'd0, dest_out, data_out}, 32'd0);
      chk("rst_cnts", {cnt_D1, cnt_D0}, 32'd0);
      chk("rst_cnt2", {28'd0, cnt2_D1, cnt2_D0}, 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_idle", {29'd0, busy, D1_pop, D0_pop}, 32'd0);

    // 3+3 words, ready high: alternate pops, stream 2 cycles behind.
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rr_c%0d_pop0", i), {31'd0, D0_pop}, {31'd0, e_p0[i]});
      chk($sformatf("rr_c%0d_pop1", i), {31'd0, D1_pop}, {31'd0, e_p1[i]});
      chk($sformatf("rr_c%0d_valid", i), {31'd0, valid_out}, {31'd0, e_v[i]});
      if (e_v[i])
        chk($sformatf("rr_c%0d_word", i), {25'd0, dest_out, data_out}, {25'd0, e_dst[i], e_d[i]});
    end
    chk("rr_cnt_D0", {24'd0, cnt_D0}, 32'd3);
    chk("rr_cnt_D1", {24'd0, cnt_D1}, 32'd3);

    // Only D1 has words.
    push1(6'h2A); push1(6'h15);
    #1;
    chk("d1only_k0_pops", {30'd0, D1_pop, D0_pop}, 32'd2);
    tick();
    chk("d1only_k1_pops", {30'd0, D1_pop, D0_pop}, 32'd2);
    tick();
    chk("d1only_k2_pops", {30'd0, D1_pop, D0_pop}, 32'd0);
    chk("d1only_k2_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b11, 6'h2A});
    tick();
    chk("d1only_k3_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b11, 6'h15});
    chk("d1only_k3_pop0", {31'd0, D0_pop}, 32'd0);
    tick();
    chk("d1only_k4_valid", {31'd0, valid_out}, 32'd0);
    chk("d1only_cnt_D1", {24'd0, cnt_D1}, 32'd5);

    // Back-pressure: 5 words in D0, sink stalled.
    ready_in = 1'b0;
    push0(6'h21); push0(6'h22); push0(6'h23); push0(6'h24); push0(6'h25);
    #1;
    chk("bp_k0_pop", {30'd0, D1_pop, D0_pop}, 32'd1);
    tick();
    chk("bp_k1_pop", {30'd0, D1_pop, D0_pop}, 32'd1);
    tick();
    chk("bp_k2_stall", {30'd0, D1_pop, D0_pop}, 32'd0);
    chk("bp_k2_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b10, 6'h21});
    tick();
    chk("bp_k3_stall", {31'd0, D0_pop}, 32'd0);
    chk("bp_k3_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b10, 6'h21});
    tick();
    chk("bp_k4_stall", {31'd0, D0_pop}, 32'd0);
    ready_in = 1'b1;
    #1;
    chk("bp_k4_resume_pop", {31'd0, D0_pop}, 32'd1);
    tick();
    chk("bp_k5_pop", {31'd0, D0_pop}, 32'd1);
    chk("bp_k5_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b10, 6'h22});
    tick();
    chk("bp_k6_pop", {31'd0, D0_pop}, 32'd1);
    chk("bp_k6_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b10, 6'h23});
    tick();
    chk("bp_k7_pop", {31'd0, D0_pop}, 32'd0);
    chk("bp_k7_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b10, 6'h24});
    tick();
    chk("bp_k8_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b10, 6'h25});
    tick();
    chk("bp_k9_valid", {31'd0, valid_out}, 32'd0);
    chk("bp_cnt_D0", {24'd0, cnt_D0}, 32'd8);

    // Drain: active drops the cycle after a pop.
    push1(6'h30);
    #1;
    chk("drain_k0_pop", {30'd0, D1_pop, D0_pop}, 32'd2);
    tick();
    active_in = 1'b0;
    #1;
    chk("drain_k1_pops_busy", {29'd0, busy, D1_pop, D0_pop}, 32'd4);
    tick();
    push0(6'h31);
    #1;
    chk("drain_k2_no_pop", {30'd0, D1_pop, D0_pop}, 32'd0);
    chk("drain_k2_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b11, 6'h30});
    tick();
    chk("drain_k3_busy", {29'd0, busy, valid_out, D0_pop}, 32'd4);
    tick();
    chk("drain_k4_idle", {29'd0, busy, valid_out, D0_pop}, 32'd0);
    chk("drain_cnt_D1", {24'd0, cnt_D1}, 32'd6);
    active_in = 1'b1;
    tick();
    chk("restart_pop", {30'd0, D1_pop, D0_pop}, 32'd1);
    tick();
    tick();
    chk("restart_word", {24'd0, valid_out, dest_out, data_out}, {24'd0, 2'b10, 6'h31});
    tick();
    chk("restart_cnt_D0", {24'd0, cnt_D0}, 32'd9);

    // Narrow-counter instance: 5 D0 words saturate a 2-bit counter.
    active2 = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    chk("sat_cnt2_D0", {30'd0, cnt2_D0}, 32'd3);
    chk("sat_cnt2_D1", {30'd0, cnt2_D1}, 32'd0);
    chk("sat_all_popped", {26'd0, head2}, 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
